// File: rtl/path_count_scheduler_pkg.sv
// Shared types and sizing for the day-11 path-count datapath.
// topological_sort, adjacency_map and node_id_mapper use the same node_t / count_t.
package path_count_scheduler_pkg;

  localparam int MAX_NODES   = 1024;
  localparam int NODE_WIDTH  = $clog2(MAX_NODES);
  localparam int COUNT_WIDTH = 16;

  typedef logic [NODE_WIDTH-1:0]  node_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_FETCH,
    ST_READ,
    ST_QUERY,
    ST_REPLY_RD,
    ST_REPLY_WR,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/path_count_scheduler_ram.sv
// Single-port path-count memory with 1-cycle registered read.
// A per-entry touched bit makes never-written entries read as zero, so no clearing pass is needed.
module path_count_ram
  import path_count_scheduler_pkg::*;
#(
  parameter int W = COUNT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         we,
  input  node_t        addr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata
);

  logic [W-1:0]         mem [MAX_NODES];
  logic [W-1:0]         mem_rd_q;
  logic [MAX_NODES-1:0] touched_q, touched_d;
  logic                 hit_q, hit_d;

  always_comb begin
    touched_d = touched_q;
    hit_d     = hit_q;
    if (en) begin
      if (we) touched_d[addr] = 1'b1;
      else    hit_d = touched_q[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      touched_q <= '0;
      hit_q     <= 1'b0;
    end else begin
      touched_q <= touched_d;
      hit_q     <= hit_d;
    end
  end

  // Plain array without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    mem_rd_q  <= mem[addr];
    end
  end

  assign rdata = hit_q ? mem_rd_q : '0;

endmodule

// File: rtl/path_count_scheduler.sv
// Forward-pass controller: buffers the topological order, then walks it propagating
// path counts from the start node through adjacency_map replies, reporting the count at the end node.
module path_count_scheduler
  import path_count_scheduler_pkg::*;
#(
  parameter int CNT_W = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_end_nodes_valid,
  input  node_t            start_node_idx,
  input  node_t            end_node_idx,
  input  logic             sorted_valid,
  input  node_t            sorted_node,
  input  logic             sorted_done,
  output logic             query_owner,
  input  logic             query_ready,
  output logic             query_valid,
  output node_t            query_data,
  output logic             reply_ready,
  input  logic             reply_valid,
  input  logic             reply_last,
  input  node_t            reply_data,
  input  logic             reply_no_edges_found,
  output logic             result_valid,
  output logic [CNT_W-1:0] result_data,
  output logic             overflow
);

  localparam logic [NODE_WIDTH:0] ORDER_FULL = (NODE_WIDTH + 1)'(MAX_NODES);
  localparam logic [NODE_WIDTH:0] PTR_ONE    = (NODE_WIDTH + 1)'(1);

  sched_state_e        state_q, state_d;
  node_t               start_q, start_d, end_q, end_d;
  node_t               u_q, u_d, v_q, v_d;
  logic [NODE_WIDTH:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    cu_q, cu_d, result_q, result_d;
  logic                last_q, last_d, rd_phase_q, rd_phase_d;
  logic                result_valid_q, result_valid_d, overflow_q, overflow_d;

  logic                ram_en, ram_we;
  node_t               ram_addr;
  logic [CNT_W-1:0]    ram_wdata, ram_rdata;
  logic [CNT_W:0]      sum_full;

  node_t               order_mem [MAX_NODES];
  node_t               order_rd_q;
  logic                order_we, order_re;

  path_count_ram #(.W(CNT_W)) u_count_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign sum_full = {1'b0, ram_rdata} + {1'b0, cu_q};

  always_comb begin
    state_d        = state_q;
    start_d        = start_q;
    end_d          = end_q;
    u_d            = u_q;
    v_d            = v_q;
    wptr_d         = wptr_q;
    rptr_d         = rptr_q;
    cu_d           = cu_q;
    result_d       = result_q;
    last_d         = last_q;
    rd_phase_d     = rd_phase_q;
    result_valid_d = 1'b0;
    overflow_d     = overflow_q;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = v_q;
    ram_wdata      = '0;
    order_we       = 1'b0;
    order_re       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_end_nodes_valid) begin
          start_d   = start_node_idx;
          end_d     = end_node_idx;
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = start_node_idx;
          ram_wdata = CNT_W'(1);
          state_d   = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (sorted_valid) begin
          if (wptr_q == ORDER_FULL) begin
            overflow_d = 1'b1;
          end else begin
            order_we = 1'b1;
            wptr_d   = wptr_q + PTR_ONE;
          end
        end
        if (sorted_done) begin
          rptr_d  = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (rptr_q == wptr_q) begin
          result_d       = '0;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          order_re   = 1'b1;
          rd_phase_d = 1'b0;
          state_d    = ST_READ;
        end
      end
      // Phase 0 issues the count read for u; phase 1 sees its data.
      ST_READ: begin
        if (!rd_phase_q) begin
          u_d        = order_rd_q;
          ram_en     = 1'b1;
          ram_addr   = order_rd_q;
          rd_phase_d = 1'b1;
        end else begin
          rd_phase_d = 1'b0;
          if (u_q == end_q) begin
            result_d       = ram_rdata;
            result_valid_d = 1'b1;
            state_d        = ST_DONE;
          end else if (ram_rdata == '0) begin
            rptr_d  = rptr_q + PTR_ONE;
            state_d = ST_FETCH;
          end else begin
            cu_d    = ram_rdata;
            state_d = ST_QUERY;
          end
        end
      end
      ST_QUERY: begin
        if (query_ready) state_d = ST_REPLY_RD;
      end
      ST_REPLY_RD: begin
        if (reply_valid) begin
          if (reply_no_edges_found) begin
            rptr_d  = rptr_q + PTR_ONE;
            state_d = ST_FETCH;
          end else begin
            v_d      = reply_data;
            last_d   = reply_last;
            ram_en   = 1'b1;
            ram_addr = reply_data;
            state_d  = ST_REPLY_WR;
          end
        end
      end
      ST_REPLY_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = v_q;
        ram_wdata = sum_full[CNT_W] ? '1 : sum_full[CNT_W-1:0];
        if (sum_full[CNT_W]) overflow_d = 1'b1;
        if (last_q) begin
          rptr_d  = rptr_q + PTR_ONE;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_REPLY_RD;
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      start_q        <= '0;
      end_q          <= '0;
      u_q            <= '0;
      v_q            <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      cu_q           <= '0;
      result_q       <= '0;
      last_q         <= 1'b0;
      rd_phase_q     <= 1'b0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_d;
      end_q          <= end_d;
      u_q            <= u_d;
      v_q            <= v_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      cu_q           <= cu_d;
      result_q       <= result_d;
      last_q         <= last_d;
      rd_phase_q     <= rd_phase_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (order_we) order_mem[wptr_q[NODE_WIDTH-1:0]] <= sorted_node;
    if (order_re) order_rd_q <= order_mem[rptr_q[NODE_WIDTH-1:0]];
  end

  // Handshake outputs decode straight from the state flop so reset drops them immediately.
  assign query_owner  = (state_q == ST_FETCH) || (state_q == ST_READ) || (state_q == ST_QUERY) ||
                        (state_q == ST_REPLY_RD) || (state_q == ST_REPLY_WR);
  assign query_valid  = (state_q == ST_QUERY);
  assign query_data   = u_q;
  assign reply_ready  = (state_q == ST_REPLY_RD);
  assign result_valid = result_valid_q;
  assign result_data  = result_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_path_count_scheduler.sv
// Bench for path_count_scheduler: a 16-bit and a 4-bit count instance share one stimulus stream,
// an adjacency responder answers queries, and a path-count model predicts queries and results.
module tb_path_count_scheduler;
  import path_count_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic  start_end_nodes_valid = 1'b0;
  node_t start_node_idx = '0, end_node_idx = '0;
  logic  sorted_valid = 1'b0, sorted_done = 1'b0;
  node_t sorted_node = '0;
  logic  query_ready = 1'b0, reply_valid = 1'b0, reply_last = 1'b0, reply_no_edges_found = 1'b0;
  node_t reply_data = '0;

  logic        query_owner, query_valid, reply_ready, result_valid, overflow;
  node_t       query_data;
  logic [15:0] result_data;
  logic        query_owner_b, query_valid_b, reply_ready_b, result_valid_b, overflow_b;
  node_t       query_data_b;
  logic [3:0]  result_data_b;

  path_count_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start_end_nodes_valid(start_end_nodes_valid),
    .start_node_idx(start_node_idx), .end_node_idx(end_node_idx),
    .sorted_valid(sorted_valid), .sorted_node(sorted_node), .sorted_done(sorted_done),
    .query_owner(query_owner), .query_ready(query_ready), .query_valid(query_valid),
    .query_data(query_data), .reply_ready(reply_ready), .reply_valid(reply_valid),
    .reply_last(reply_last), .reply_data(reply_data), .reply_no_edges_found(reply_no_edges_found),
    .result_valid(result_valid), .result_data(result_data), .overflow(overflow)
  );

  path_count_scheduler #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .start_end_nodes_valid(start_end_nodes_valid),
    .start_node_idx(start_node_idx), .end_node_idx(end_node_idx),
    .sorted_valid(sorted_valid), .sorted_node(sorted_node), .sorted_done(sorted_done),
    .query_owner(query_owner_b), .query_ready(query_ready), .query_valid(query_valid_b),
    .query_data(query_data_b), .reply_ready(reply_ready_b), .reply_valid(reply_valid),
    .reply_last(reply_last), .reply_data(reply_data), .reply_no_edges_found(reply_no_edges_found),
    .result_valid(result_valid_b), .result_data(result_data_b), .overflow(overflow_b)
  );

  int     errors = 0, checks = 0;
  string  cur_case = "init";
  int     edge_src[$], edge_dst[$], order_q[$];
  int     s_node, e_node;
  bit     bp_mode = 1'b0;
  longint exp_res16, exp_res4;
  bit     exp_ovf16, exp_ovf4;
  int     exp_queries[$];
  int     results_seen = 0, stall_cycles = 0;
  bit     prev_qwait = 1'b0;
  node_t  prev_qdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d", cur_case, name, act, exp);
    end
  endtask

  task automatic add_edge(input int s, input int d);
    edge_src.push_back(s);
    edge_dst.push_back(d);
  endtask

  // Path counts by dynamic programming over the (truncated) order, unbounded then clipped.
  function automatic void build_model();
    longint cnt [int];
    longint c;
    int     n;
    bit     sat16, sat4;
    cnt[s_node] = 1;
    exp_queries.delete();
    exp_res16 = 0;
    sat16 = 0;
    sat4 = 0;
    c = 0;
    n = (order_q.size() > MAX_NODES) ? MAX_NODES : order_q.size();
    for (int i = 0; i < n; i++) begin
      int u;
      u = order_q[i];
      c = cnt.exists(u) ? cnt[u] : 0;
      if (u == e_node) begin
        exp_res16 = c;
        break;
      end
      if (c == 0) continue;
      exp_queries.push_back(u);
      foreach (edge_src[k]) begin
        if (edge_src[k] == u) begin
          int v;
          v = edge_dst[k];
          cnt[v] = (cnt.exists(v) ? cnt[v] : 0) + c;
          if (cnt[v] > 65535) sat16 = 1;
          if (cnt[v] > 15) sat4 = 1;
        end
      end
    end
    exp_res4  = (exp_res16 > 15) ? 15 : exp_res16;
    if (exp_res16 > 65535) exp_res16 = 65535;
    exp_ovf16 = (order_q.size() > MAX_NODES) || sat16;
    exp_ovf4  = (order_q.size() > MAX_NODES) || sat4;
  endfunction

  // Adjacency responder: queues successors per query, optional backpressure and reply gaps.
  initial begin
    int  beats[$];
    int  gap, qwait;
    bit  q_hs, r_hs;
    node_t q_u;
    gap = 0;
    qwait = 0;
    forever begin
      @(negedge clk);
      q_hs = rst_n && query_valid && query_ready;
      r_hs = rst_n && reply_valid && reply_ready;
      q_u  = query_data;
      if (rst_n && query_valid && !query_ready) qwait++;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        beats.delete();
        reply_valid = 1'b0;
        query_ready = 1'b0;
        qwait = 0;
        gap = 0;
        continue;
      end
      if (q_hs) begin
        qwait = 0;
        foreach (edge_src[k]) if (edge_src[k] == int'(q_u)) beats.push_back(edge_dst[k]);
        if (beats.size() == 0) beats.push_back(-1);
        gap = bp_mode ? int'($urandom_range(0, 3)) : 0;
      end
      if (r_hs) begin
        void'(beats.pop_front());
        gap = bp_mode ? int'($urandom_range(0, 3)) : 0;
      end
      if (!bp_mode) query_ready = 1'b1;
      else          query_ready = !q_hs && (qwait >= 7);
      if (beats.size() > 0 && gap == 0) begin
        reply_valid          = 1'b1;
        reply_no_edges_found = (beats[0] < 0);
        reply_data           = (beats[0] < 0) ? node_t'(0) : node_t'(beats[0]);
        reply_last           = (beats.size() == 1);
      end else begin
        if (gap > 0) gap--;
        reply_valid = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs",
          {14'd0, query_owner, query_valid, query_data, reply_ready, result_valid, result_data, overflow,
           query_owner_b, query_valid_b, query_data_b, reply_ready_b, result_valid_b, result_data_b, overflow_b},
          64'd0);
      prev_qwait = 1'b0;
    end else begin
      if (query_valid || reply_ready) chk("query_owner", query_owner, 1);
      if (prev_qwait) chk("query_hold", query_data, prev_qdata);
      if (query_valid && !query_ready) stall_cycles++;
      prev_qwait = query_valid && !query_ready;
      prev_qdata = query_data;
      if (query_valid && query_ready) begin
        if (exp_queries.size() == 0) chk("unexpected_query", query_data, 64'hFFFF);
        else                         chk("query_node", query_data, exp_queries.pop_front());
      end
      if (result_valid) begin
        results_seen++;
        chk("result_once", results_seen, 1);
        chk("result_data", result_data, exp_res16);
        chk("overflow", overflow, exp_ovf16);
        chk("result_valid_w4", result_valid_b, 1);
        chk("result_data_w4", result_data_b, exp_res4);
        chk("overflow_w4", overflow_b, exp_ovf4);
      end else if (results_seen > 0) begin
        chk("result_hold", result_data, exp_res16);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    results_seen = 0;
    stall_cycles = 0;
    start_end_nodes_valid = 1'b0;
    sorted_valid = 1'b0;
    sorted_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_case(input string name, input bit abort);
    int cyc, hs;
    cur_case = name;
    build_model();
    do_reset();
    start_end_nodes_valid = 1'b1;
    start_node_idx = node_t'(s_node);
    end_node_idx   = node_t'(e_node);
    @(posedge clk); #1;
    start_end_nodes_valid = 1'b0;
    if (order_q.size() == 0) begin
      sorted_done = 1'b1;
      @(posedge clk); #1;
    end
    foreach (order_q[i]) begin
      sorted_valid = 1'b1;
      sorted_node  = node_t'(order_q[i]);
      sorted_done  = (i == order_q.size() - 1);
      @(posedge clk); #1;
    end
    sorted_valid = 1'b0;
    sorted_done  = 1'b0;
    if (abort) begin
      cyc = 0;
      hs = 0;
      while (hs < 2 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
        if (reply_valid && reply_ready) hs++;
      end
      chk("abort_reply_seen", hs, 2);
      @(posedge clk); #3;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_query_valid", query_valid, 0);
      chk("abort_reply_ready", reply_ready, 0);
      return;
    end
    cyc = 0;
    while (results_seen == 0 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("result_seen", results_seen > 0, 1);
    start_end_nodes_valid = 1'b1;
    sorted_valid = 1'b1;
    sorted_done  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start_end_nodes_valid = 1'b0;
    sorted_valid = 1'b0;
    sorted_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("all_queries_issued", exp_queries.size(), 0);
    $display("case %s: result=%0d overflow=%0d result_w4=%0d overflow_w4=%0d",
             name, result_data, overflow, result_data_b, overflow_b);
  endtask

  task automatic set_diamond();
    edge_src.delete();
    edge_dst.delete();
    add_edge(0, 1); add_edge(0, 2); add_edge(1, 3); add_edge(2, 3); add_edge(3, 4);
    order_q = '{0, 1, 2, 3, 4};
  endtask

  initial begin
    #1;

    set_diamond(); s_node = 0; e_node = 4;
    run_case("diamond", 0);
    chk("lit_diamond", result_data, 2);
    chk("lit_diamond_ovf", overflow, 0);

    e_node = 2;
    run_case("diamond_end2", 0);
    chk("lit_end2", result_data, 1);

    s_node = 3; e_node = 3;
    run_case("start_eq_end", 0);
    chk("lit_start_eq_end", result_data, 1);

    s_node = 0; e_node = 7;
    run_case("end_absent", 0);
    chk("lit_end_absent", result_data, 0);

    edge_src.delete(); edge_dst.delete();
    add_edge(0, 1); add_edge(2, 3);
    order_q = '{0, 1, 2, 3};
    s_node = 0; e_node = 3;
    run_case("unreachable", 0);
    chk("lit_unreachable", result_data, 0);

    order_q.delete();
    run_case("empty_order", 0);
    chk("lit_empty", result_data, 0);

    // Start 0 -> two nodes per layer, five layers fully connected, then end 11: 2^5 paths.
    edge_src.delete(); edge_dst.delete();
    add_edge(0, 1); add_edge(0, 2);
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 2; a++)
        for (int b = 0; b < 2; b++) add_edge(1 + 2 * l + a, 3 + 2 * l + b);
    add_edge(9, 11); add_edge(10, 11);
    order_q.delete();
    for (int i = 0; i < 12; i++) order_q.push_back(i);
    s_node = 0; e_node = 11;
    run_case("saturate", 0);
    chk("lit_sat16", result_data, 32);
    chk("lit_sat16_ovf", overflow, 0);
    chk("lit_sat4", result_data_b, 15);
    chk("lit_sat4_ovf", overflow_b, 1);

    set_diamond(); s_node = 0; e_node = 4;
    bp_mode = 1'b1;
    run_case("backpressure", 0);
    chk("lit_bp_result", result_data, 2);
    chk("lit_bp_stalls", stall_cycles, 28);
    bp_mode = 1'b0;

    run_case("abort_reply_wr", 1);
    run_case("diamond_rerun", 0);
    chk("lit_rerun", result_data, 2);

    edge_src.delete(); edge_dst.delete();
    order_q.delete();
    for (int i = 0; i < MAX_NODES; i++) order_q.push_back(i);
    order_q.push_back(5);
    s_node = 0; e_node = 1000;
    run_case("order_overrun", 0);
    chk("lit_overrun_result", result_data, 0);
    chk("lit_overrun_ovf", overflow, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
